// File: rtl/atm_pkg.sv
// Shared types and default sizes for the ATM ledger arbiter: op codes, status
// codes, FSM state encoding and parameter defaults.
package atm_pkg;

   localparam int DEF_N_ACCT = 3;
   localparam int DEF_BAL_W  = 12;
   localparam int DEF_AMT_W  = 8;
   localparam int IDX_W      = 2;

   typedef enum logic [1:0] {
      OP_DEPOSIT  = 2'd0,
      OP_WITHDRAW = 2'd1,
      OP_TRANSFER = 2'd2,
      OP_BALANCE  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_NSF      = 2'd1,
      ST_BAD_ACCT = 2'd2,
      ST_OVERFLOW = 2'd3
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CHECK = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/atm_ledger.sv
// Account balance register file: two combinational read ports, two write
// ports committed on the same edge, synchronous reload of opening balances.
module atm_ledger
   import atm_pkg::*;
#(
   parameter int               N_ACCT = DEF_N_ACCT,
   parameter int               BAL_W  = DEF_BAL_W,
   parameter logic [BAL_W-1:0] INIT0  = 12'h457,
   parameter logic [BAL_W-1:0] INIT1  = 12'h8AE,
   parameter logic [BAL_W-1:0] INIT2  = 12'hD05
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_a_i,
   output logic [BAL_W-1:0] rd_data_a_o,
   input  logic [IDX_W-1:0] rd_idx_b_i,
   output logic [BAL_W-1:0] rd_data_b_o,
   input  logic             we_a_i,
   input  logic [IDX_W-1:0] wr_idx_a_i,
   input  logic [BAL_W-1:0] wr_data_a_i,
   input  logic             we_b_i,
   input  logic [IDX_W-1:0] wr_idx_b_i,
   input  logic [BAL_W-1:0] wr_data_b_i
);

   logic [BAL_W-1:0] mem_q [N_ACCT];

   function automatic logic [BAL_W-1:0] init_val(input int idx);
      case (idx)
         0:       return INIT0;
         1:       return INIT1;
         2:       return INIT2;
         default: return '0;
      endcase
   endfunction

   // Out-of-range indices read as zero so a bad account never sees X.
   assign rd_data_a_o = (int'(rd_idx_a_i) < N_ACCT) ? mem_q[rd_idx_a_i] : '0;
   assign rd_data_b_o = (int'(rd_idx_b_i) < N_ACCT) ? mem_q[rd_idx_b_i] : '0;

   // NOTE: storage arrays are normally left unreset; this one holds the opening
   // balances, so every entry reloads. Sequential state uses <= throughout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ACCT; i++) mem_q[i] <= init_val(i);
      end else begin
         if (we_a_i) mem_q[wr_idx_a_i] <= wr_data_a_i;
         if (we_b_i) mem_q[wr_idx_b_i] <= wr_data_b_i;
      end
   end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter serialising two ATM requesters onto one ledger; each
// grant runs an atomic read-check-write sequence and returns status/balances.
module atm_ledger_arbiter
   import atm_pkg::*;
#(
   parameter int               N_ACCT = DEF_N_ACCT,
   parameter int               BAL_W  = DEF_BAL_W,
   parameter int               AMT_W  = DEF_AMT_W,
   parameter logic [BAL_W-1:0] INIT0  = 12'h457,
   parameter logic [BAL_W-1:0] INIT1  = 12'h8AE,
   parameter logic [BAL_W-1:0] INIT2  = 12'hD05
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [1:0]       op0,
   input  logic [1:0]       op1,
   input  logic [1:0]       src0,
   input  logic [1:0]       src1,
   input  logic [1:0]       dst0,
   input  logic [1:0]       dst1,
   input  logic [AMT_W-1:0] amt0,
   input  logic [AMT_W-1:0] amt1,
   output logic [1:0]       ack,
   output logic [1:0]       status,
   output logic [BAL_W-1:0] rsp_bal,
   output logic [BAL_W-1:0] rsp_dst_bal,
   output logic             busy
);

   state_e           state_q;
   logic             grant_q, last_grant_q, win_d;
   op_e              op_q;
   logic [IDX_W-1:0] src_q, dst_q;
   logic [AMT_W-1:0] amt_q;
   logic [BAL_W-1:0] src_bal_q, dst_bal_q, rd_src, rd_dst;
   status_e          st_q, st_d;
   logic [BAL_W-1:0] new_src_q, new_dst_q, new_src_d, new_dst_d;
   logic [1:0]       ack_q;
   status_e          status_q;
   logic [BAL_W-1:0] rsp_bal_q, rsp_dst_q;
   logic             busy_q;
   logic             wr_en;

   // Sums carry one extra bit so overflow shows up as the MSB.
   logic [BAL_W:0] amt_ext, src_sum, dst_sum;
   logic           nsf, src_ok, dst_ok;

   assign amt_ext = (BAL_W + 1)'(amt_q);
   assign src_sum = {1'b0, src_bal_q} + amt_ext;
   assign dst_sum = {1'b0, dst_bal_q} + amt_ext;
   assign nsf     = amt_ext > {1'b0, src_bal_q};
   assign src_ok  = int'(src_q) < N_ACCT;
   assign dst_ok  = int'(dst_q) < N_ACCT;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      win_d = 1'b0;
      case (req)
         2'b10:   win_d = 1'b1;
         2'b11:   win_d = ~last_grant_q;
         default: win_d = 1'b0;
      endcase
   end

   always_comb begin
      st_d      = ST_OK;
      new_src_d = src_bal_q;
      new_dst_d = dst_bal_q;
      if (!src_ok || (op_q == OP_TRANSFER && (!dst_ok || dst_q == src_q))) begin
         st_d = ST_BAD_ACCT;
      end else begin
         case (op_q)
            OP_DEPOSIT: begin
               if (src_sum[BAL_W]) st_d = ST_OVERFLOW;
               else                new_src_d = src_sum[BAL_W-1:0];
            end
            OP_WITHDRAW: begin
               if (nsf) st_d = ST_NSF;
               else     new_src_d = src_bal_q - amt_ext[BAL_W-1:0];
            end
            OP_TRANSFER: begin
               if (nsf) begin
                  st_d = ST_NSF;
               end else if (dst_sum[BAL_W]) begin
                  st_d = ST_OVERFLOW;
               end else begin
                  new_src_d = src_bal_q - amt_ext[BAL_W-1:0];
                  new_dst_d = dst_sum[BAL_W-1:0];
               end
            end
            default: st_d = ST_OK;
         endcase
      end
   end

   assign wr_en = (state_q == S_WRITE) && (st_q == ST_OK) && (op_q != OP_BALANCE);

   atm_ledger #(
      .N_ACCT (N_ACCT),
      .BAL_W  (BAL_W),
      .INIT0  (INIT0),
      .INIT1  (INIT1),
      .INIT2  (INIT2)
   ) u_ledger (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx_a_i  (src_q),
      .rd_data_a_o (rd_src),
      .rd_idx_b_i  (dst_q),
      .rd_data_b_o (rd_dst),
      .we_a_i      (wr_en),
      .wr_idx_a_i  (src_q),
      .wr_data_a_i (new_src_q),
      .we_b_i      (wr_en && (op_q == OP_TRANSFER)),
      .wr_idx_b_i  (dst_q),
      .wr_data_b_i (new_dst_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         op_q         <= OP_DEPOSIT;
         src_q        <= '0;
         dst_q        <= '0;
         amt_q        <= '0;
         src_bal_q    <= '0;
         dst_bal_q    <= '0;
         st_q         <= ST_OK;
         new_src_q    <= '0;
         new_dst_q    <= '0;
         ack_q        <= '0;
         status_q     <= ST_OK;
         rsp_bal_q    <= '0;
         rsp_dst_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         ack_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (|req) begin
                  grant_q      <= win_d;
                  last_grant_q <= win_d;
                  op_q         <= win_d ? op_e'(op1) : op_e'(op0);
                  src_q        <= win_d ? src1 : src0;
                  dst_q        <= win_d ? dst1 : dst0;
                  amt_q        <= win_d ? amt1 : amt0;
                  busy_q       <= 1'b1;
                  state_q      <= S_READ;
               end
            end
            S_READ: begin
               src_bal_q <= rd_src;
               dst_bal_q <= rd_dst;
               state_q   <= S_CHECK;
            end
            S_CHECK: begin
               st_q      <= st_d;
               new_src_q <= new_src_d;
               new_dst_q <= new_dst_d;
               state_q   <= S_WRITE;
            end
            S_WRITE: begin
               status_q  <= st_q;
               rsp_bal_q <= new_src_q;
               rsp_dst_q <= (op_q == OP_TRANSFER) ? new_dst_q : '0;
               state_q   <= S_RESP;
            end
            S_RESP: begin
               ack_q   <= grant_q ? 2'b10 : 2'b01;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ack         = ack_q;
   assign status      = status_q;
   assign rsp_bal     = rsp_bal_q;
   assign rsp_dst_bal = rsp_dst_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Self-checking bench for atm_ledger_arbiter: directed scenarios plus random
// traffic compared against a plain-arithmetic ledger model.
module tb_atm_ledger_arbiter;
   import atm_pkg::*;

   localparam int NA   = 3;
   localparam int MAXB = 4095;

   typedef struct packed {
      logic [1:0]  ack;
      logic [3:0]  lat;
      logic        busy_mid;
      logic        busy_ack;
      logic [1:0]  st;
      logic [11:0] bal;
      logic [11:0] dbal;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = '0;
   logic [1:0]  op0 = '0, op1 = '0, src0 = '0, src1 = '0, dst0 = '0, dst1 = '0;
   logic [7:0]  amt0 = '0, amt1 = '0;
   logic [1:0]  ack, status, ack_b, status_b;
   logic [11:0] rsp_bal, rsp_dst_bal, rsp_bal_b, rsp_dst_bal_b;
   logic        busy, busy_b;

   int   n_pass = 0;
   int   n_total = 0;
   int   model_bal [NA];
   int   last_grant = 1;
   rsp_t obs, obs_b, exp_r, exp_b;

   always #5 clk = ~clk;

   atm_ledger_arbiter u_dut (
      .clk (clk), .rst_n (rst_n), .req (req),
      .op0 (op0), .op1 (op1), .src0 (src0), .src1 (src1),
      .dst0 (dst0), .dst1 (dst1), .amt0 (amt0), .amt1 (amt1),
      .ack (ack), .status (status), .rsp_bal (rsp_bal),
      .rsp_dst_bal (rsp_dst_bal), .busy (busy)
   );

   // Same stimulus, different opening balances for the NSF/overflow cases.
   atm_ledger_arbiter #(.INIT0 (12'h010), .INIT2 (12'hFF0)) u_alt (
      .clk (clk), .rst_n (rst_n), .req (req),
      .op0 (op0), .op1 (op1), .src0 (src0), .src1 (src1),
      .dst0 (dst0), .dst1 (dst1), .amt0 (amt0), .amt1 (amt1),
      .ack (ack_b), .status (status_b), .rsp_bal (rsp_bal_b),
      .rsp_dst_bal (rsp_dst_bal_b), .busy (busy_b)
   );

   task automatic model_reset();
      model_bal  = '{'h457, 'h8AE, 'hD05};
      last_grant = 1;
   endtask

   task automatic model_step(input int r, input int op, input int src, input int dst,
                             input int amt, output rsp_t e);
      int sb, db, st, nb, nd;
      sb = (src < NA) ? model_bal[src] : 0;
      db = (dst < NA) ? model_bal[dst] : 0;
      nb = sb;
      nd = db;
      if (src >= NA || (op == 2 && (dst >= NA || dst == src))) st = 2;
      else if (op == 0) begin
         if (sb + amt > MAXB) st = 3;
         else begin st = 0; nb = sb + amt; end
      end else if (op == 1) begin
         if (amt > sb) st = 1;
         else begin st = 0; nb = sb - amt; end
      end else if (op == 2) begin
         if (amt > sb) st = 1;
         else if (db + amt > MAXB) st = 3;
         else begin st = 0; nb = sb - amt; nd = db + amt; end
      end else st = 0;
      if (st == 0 && src < NA) model_bal[src] = nb;
      if (st == 0 && op == 2) model_bal[dst] = nd;
      last_grant = r;
      e = {2'(1 << r), 4'd5, 1'b1, 1'b0, 2'(st), 12'(nb), (op == 2) ? 12'(nd) : 12'h000};
   endtask

   task automatic drive_fields(input int r, input int op, input int src, input int dst,
                               input int amt);
      if (r == 0) begin
         op0 = 2'(op); src0 = 2'(src); dst0 = 2'(dst); amt0 = 8'(amt);
      end else begin
         op1 = 2'(op); src1 = 2'(src); dst1 = 2'(dst); amt1 = 8'(amt);
      end
   endtask

   task automatic wait_ack(output rsp_t o, output rsp_t ob);
      int   cyc;
      logic bmid;
      cyc  = 0;
      bmid = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) bmid = busy;
      end while (ack == 2'b00 && cyc < 15);
      o  = {ack, 4'(cyc), bmid, busy, status, rsp_bal, rsp_dst_bal};
      ob = {ack_b, 4'(cyc), bmid, busy_b, status_b, rsp_bal_b, rsp_dst_bal_b};
   endtask

   task automatic run_single(input int r, input int op, input int src, input int dst,
                             input int amt);
      drive_fields(r, op, src, dst, amt);
      req[r] = 1'b1;
      wait_ack(obs, obs_b);
      req[r] = 1'b0;
      model_step(r, op, src, dst, amt, exp_r);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({ack, busy, status, rsp_bal, rsp_dst_bal} !== 29'h0)
         $display("FAIL reset_state: got %h want 0", {ack, busy, status, rsp_bal, rsp_dst_bal});
      else n_pass++;
      run_single(0, 0, 1, 0, 'h22);
      do_reset();
      n_total++;
      if ({ack, busy, status, rsp_bal, rsp_dst_bal, ack_b, busy_b, rsp_bal_b} !== 44'h0)
         $display("FAIL reset_after_txn: got %h want 0",
                  {ack, busy, status, rsp_bal, rsp_dst_bal, ack_b, busy_b, rsp_bal_b});
      else n_pass++;
   endtask

   task automatic test_deposit();
      do_reset();
      run_single(0, 0, 0, 0, 'h10);
      n_total++;
      if (obs !== exp_r) $display("FAIL deposit: got %h want %h", obs, exp_r);
      else n_pass++;
      n_total++;
      if (obs.bal !== 12'h467) $display("FAIL deposit_bal: got %h want 467", obs.bal);
      else n_pass++;
   endtask

   task automatic test_transfer();
      do_reset();
      run_single(1, 2, 2, 0, 'h05);
      n_total++;
      if (obs !== exp_r) $display("FAIL transfer: got %h want %h", obs, exp_r);
      else n_pass++;
      n_total++;
      if ({obs.st, obs.bal, obs.dbal} !== {ST_OK, 12'hD00, 12'h45C})
         $display("FAIL transfer_bals: got %h want 0d0045c", {obs.st, obs.bal, obs.dbal});
      else n_pass++;
      run_single(0, 3, 0, 0, 0);
      n_total++;
      if (obs !== exp_r || obs.bal !== 12'h45C)
         $display("FAIL balance_after_transfer: got %h want %h", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_contention();
      do_reset();
      drive_fields(0, 1, 1, 0, 'h80);
      drive_fields(1, 3, 1, 0, 'h00);
      req = 2'b11;
      wait_ack(obs, obs_b);
      req[0] = 1'b0;
      model_step(0, 1, 1, 0, 'h80, exp_r);
      n_total++;
      if (obs !== exp_r || obs.bal !== 12'h82E)
         $display("FAIL contention_first: got %h want %h", obs, exp_r);
      else n_pass++;
      wait_ack(obs, obs_b);
      req[1] = 1'b0;
      model_step(1, 3, 1, 0, 'h00, exp_r);
      n_total++;
      if (obs !== exp_r || obs.bal !== 12'h82E)
         $display("FAIL contention_second: got %h want %h", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_nsf_overflow();
      do_reset();
      run_single(0, 1, 0, 0, 'h20);
      exp_b = {2'b01, 4'd5, 1'b1, 1'b0, ST_NSF, 12'h010, 12'h000};
      n_total++;
      if (obs_b !== exp_b) $display("FAIL withdraw_nsf: got %h want %h", obs_b, exp_b);
      else n_pass++;
      n_total++;
      if (obs !== exp_r) $display("FAIL withdraw_main: got %h want %h", obs, exp_r);
      else n_pass++;
      run_single(0, 0, 2, 0, 'h20);
      exp_b = {2'b01, 4'd5, 1'b1, 1'b0, ST_OVERFLOW, 12'hFF0, 12'h000};
      n_total++;
      if (obs_b !== exp_b) $display("FAIL deposit_overflow: got %h want %h", obs_b, exp_b);
      else n_pass++;
      run_single(0, 3, 0, 0, 0);
      exp_b = {2'b01, 4'd5, 1'b1, 1'b0, ST_OK, 12'h010, 12'h000};
      n_total++;
      if (obs_b !== exp_b) $display("FAIL nsf_no_write: got %h want %h", obs_b, exp_b);
      else n_pass++;
      run_single(0, 3, 2, 0, 0);
      exp_b = {2'b01, 4'd5, 1'b1, 1'b0, ST_OK, 12'hFF0, 12'h000};
      n_total++;
      if (obs_b !== exp_b) $display("FAIL overflow_no_write: got %h want %h", obs_b, exp_b);
      else n_pass++;
   endtask

   task automatic test_bad_account();
      do_reset();
      run_single(0, 2, 1, 1, 'h33);
      n_total++;
      if (obs !== exp_r || obs.st !== ST_BAD_ACCT)
         $display("FAIL transfer_same_acct: got %h want %h", obs, exp_r);
      else n_pass++;
      run_single(1, 0, 3, 0, 'h12);
      n_total++;
      if (obs !== exp_r || obs.st !== ST_BAD_ACCT)
         $display("FAIL deposit_bad_src: got %h want %h", obs, exp_r);
      else n_pass++;
      run_single(0, 3, 1, 0, 0);
      n_total++;
      if (obs !== exp_r || obs.bal !== 12'h8AE)
         $display("FAIL bad_acct_no_write: got %h want %h", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [1:0] ack_seen;
      logic       busy_at_check;
      do_reset();
      drive_fields(0, 0, 0, 0, 'h40);
      req = 2'b01;
      repeat (2) @(negedge clk);
      busy_at_check = busy;
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if ({busy_at_check, busy, ack} !== 4'b1000)
         $display("FAIL reset_mid_busy: got %b want 1000", {busy_at_check, busy, ack});
      else n_pass++;
      req   = '0;
      rst_n = 1'b1;
      ack_seen = '0;
      repeat (8) begin
         @(negedge clk);
         ack_seen |= ack;
      end
      n_total++;
      if (ack_seen !== 2'b00) $display("FAIL reset_mid_no_ack: got %b want 00", ack_seen);
      else n_pass++;
      model_reset();
      run_single(0, 3, 0, 0, 0);
      n_total++;
      if (obs !== exp_r || obs.bal !== 12'h457)
         $display("FAIL reset_mid_ledger: got %h want %h", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 60; i++) begin
         int r, op, src, dst, amt;
         r   = $urandom_range(0, 1);
         op  = $urandom_range(0, 3);
         src = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         dst = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         amt = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
         run_single(r, op, src, dst, amt);
         n_total++;
         if (obs !== exp_r) $display("FAIL random_%0d: got %h want %h", i, obs, exp_r);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         int op [2], src [2], dst [2], amt [2];
         int first, second;
         for (int r = 0; r < 2; r++) begin
            op[r]  = $urandom_range(0, 3);
            src[r] = $urandom_range(0, 2);
            dst[r] = $urandom_range(0, 2);
            amt[r] = $urandom_range(0, 255);
            drive_fields(r, op[r], src[r], dst[r], amt[r]);
         end
         first  = 1 - last_grant;
         second = last_grant;
         req = 2'b11;
         wait_ack(obs, obs_b);
         req[first] = 1'b0;
         model_step(first, op[first], src[first], dst[first], amt[first], exp_r);
         n_total++;
         if (obs !== exp_r) $display("FAIL b2b_first_%0d: got %h want %h", i, obs, exp_r);
         else n_pass++;
         wait_ack(obs, obs_b);
         req[second] = 1'b0;
         model_step(second, op[second], src[second], dst[second], amt[second], exp_r);
         n_total++;
         if (obs !== exp_r) $display("FAIL b2b_second_%0d: got %h want %h", i, obs, exp_r);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_deposit();
      test_transfer();
      test_contention();
      test_nsf_overflow();
      test_bad_account();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/atm_ledger_arbiter.md
# atm_ledger_arbiter

Shared-ledger controller for the ATM design. It serializes banking transactions from two ATM front-end requesters onto one account ledger of N_ACCT balances. Each granted request runs as an atomic read–check–write sequence, so concurrent deposits, withdrawals and transfers can never interleave or partially commit. It sits between the per-terminal ATM state machines and the account balance storage, and returns a status code and post-transaction balances to the granted requester.

## Interface
Parameters:
- N_ACCT, 3: number of ledger accounts; valid indices are 0..N_ACCT-1.
- BAL_W, 12: balance width in bits.
- AMT_W, 8: amount width in bits.
- INIT0 / INIT1 / INIT2, 12'h457 / 12'h8AE / 12'hD05: balances loaded at reset.

Ports:
- clk, input, 1: the single clock; rising edge.
- rst_n, input, 1: reset. Synchronous and active-low.
- req, input, 2: per-requester request. Must be held until that requester's ack.
- op0 / op1, input, 2 each: operation. 0 = DEPOSIT, 1 = WITHDRAW, 2 = TRANSFER, 3 = BALANCE.
- src0 / src1, input, 2 each: source account index.
- dst0 / dst1, input, 2 each: destination account index. Used by TRANSFER only.
- amt0 / amt1, input, AMT_W each: transaction amount.
- ack, output, 2: one-hot, one-cycle completion pulse to the granted requester.
- status, output, 2: 0 = OK, 1 = NSF (insufficient funds), 2 = BAD_ACCT, 3 = OVERFLOW.
- rsp_bal, output, BAL_W: source balance after the transaction.
- rsp_dst_bal, output, BAL_W: destination balance after the transaction. TRANSFER only, otherwise 0.
- busy, output, 1: high in every state except IDLE.

## Operation
- **FSM states:** IDLE → READ → CHECK → WRITE → RESP → IDLE.
- **IDLE:** on a rising edge with |req, pick the winner, capture its op/src/dst/amt into internal registers, record the grant, go to READ. Requester fields need only be stable at this sampling edge.
- **Arbitration:** round-robin.
  - If only one requester is active, it wins.
  - If both are active, the one not granted last wins.
  - After reset, requester 0 wins the first tie.
- **READ:** register ledger[src] and ledger[dst].
- **CHECK:** compute the status and the new balances. Status rules are checked in this priority order:
  1. src ≥ N_ACCT, or (TRANSFER and (dst ≥ N_ACCT or dst == src)) → BAD_ACCT.
  2. DEPOSIT: bal + amt > 2^BAL_W − 1 → OVERFLOW; otherwise new = bal + amt.
  3. WITHDRAW: amt > bal → NSF; otherwise new = bal − amt.
  4. TRANSFER: amt > src_bal → NSF; else dst_bal + amt overflows → OVERFLOW; otherwise src −= amt and dst += amt.
  5. BALANCE: always OK; no write.
- **Arithmetic width:** all sums are computed BAL_W+1 bits wide and the amount is zero-extended. amt == 0 yields OK and unchanged balances.
- **WRITE:** commit only when status == OK and the op is not BALANCE. For TRANSFER, both accounts are written on the same edge. A failed transaction writes nothing.
- **RESP:**
  - ack[grant] = 1 for exactly one cycle.
  - status, rsp_bal and rsp_dst_bal are updated on entry to RESP and hold until the next RESP.
  - On failure, rsp_bal and rsp_dst_bal report the unchanged balances.
- **Early req drop:** if req is dropped after it was granted, the transaction still completes and ack still pulses.

## Timing
- **Reset (rst_n low at an edge):**
  - State goes to IDLE; ack, status, rsp_bal, rsp_dst_bal and busy go to 0.
  - The last-grant pointer is set so that requester 0 wins the first tie.
  - The ledger reloads INIT0..INIT2.
- **Reset mid-transaction:** the in-flight transaction is abandoned and no ack is issued. Because the commit is a single edge, the ledger is either fully pre- or fully post-transaction, then reinitialised.
- **Latency:** req sampled at edge k in IDLE → ack high during the cycle after edge k+4. The ledger is updated at edge k+3.
- **Throughput:** one transaction per 5 cycles.
- **After ack:** the requester must drop req by the edge ending its ack cycle. A req still high at the following IDLE edge is treated as a new request.
- **Simultaneous requests:** both requesters asserting in the same IDLE cycle are both served, in round-robin order, back-to-back: 5 cycles, then 5 cycles.

## Structure
- **Shared package atm_pkg** holds:
  - op codes: OP_DEPOSIT, OP_WITHDRAW, OP_TRANSFER, OP_BALANCE;
  - status codes: ST_OK, ST_NSF, ST_BAD_ACCT, ST_OVERFLOW;
  - FSM state encodings;
  - the default N_ACCT, BAL_W and AMT_W values.
- **Sub-module atm_ledger:** the N_ACCT × BAL_W register file with:
  - two combinational read ports;
  - two write ports with enables, committed on the same edge;
  - synchronous reload from the INIT parameters on reset.
- **Top module:** arbiter, FSM, capture registers and check arithmetic.

## Test plan
- **Deposit:** after reset, req0 DEPOSIT src=0 amt=8'h10 → ack[0] in the 5th cycle, status OK, rsp_bal 12'h467.
- **Transfer:** req1 TRANSFER src=2 dst=0 amt=8'h05 from reset → OK, rsp_bal 12'hD00, rsp_dst_bal 12'h45C; BALANCE src=0 then returns 12'h45C.
- **Contention:** req0 WITHDRAW src=1 amt=8'h80 and req1 BALANCE src=1 raised in the same cycle →
  - requester 0 acked first: OK, 12'h82E;
  - requester 1 acked 5 cycles later: 12'h82E.
- **NSF and overflow:** with INIT0=12'h010 and INIT2=12'hFF0:
  - WITHDRAW src=0 amt=8'h20 → NSF, rsp_bal 12'h010;
  - DEPOSIT src=2 amt=8'h20 → OVERFLOW, rsp_bal 12'hFF0;
  - ledger unchanged in both cases.
- **Bad account:** TRANSFER src=1 dst=1, and DEPOSIT src=3 → BAD_ACCT, no ledger write.
- **Reset mid-operation:** rst_n low while in CHECK of a DEPOSIT → no ack; ledger reads INIT values; busy 0 at the next edge.
